// File: rtl/router_sync_n.sv
// Channel synchroniser for the 1xN router: latches the destination on header detect, steers
// the FIFO write strobe, returns the selected full flag and times out undrained channels.
module router_sync_n #(
    parameter int unsigned NCH     = 3,
    parameter int unsigned ADDR_W  = 2,
    parameter int unsigned TIMEOUT = 30,
    parameter int unsigned CNT_W   = 5
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              detect_add,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              write_en_reg,
    input  logic [NCH-1:0]    read_en,
    input  logic [NCH-1:0]    full,
    input  logic [NCH-1:0]    empty,
    output logic [NCH-1:0]    valid_out,
    output logic [NCH-1:0]    soft_reset,
    output logic              fifo_full,
    output logic [NCH-1:0]    write_en,
    output logic              addr_err
);

    logic [ADDR_W-1:0] addr_q;
    logic              addr_vld;
    logic              addr_in_range;
    logic [CNT_W-1:0]  cnt_q [NCH];

    assign addr_in_range = 32'(data_in) < NCH;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q   <= '0;
            addr_vld <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if (detect_add) begin
                if (addr_in_range) begin
                    addr_q   <= data_in;
                    addr_vld <= 1'b1;
                end else begin
                    addr_vld <= 1'b0;
                    addr_err <= 1'b1;
                end
            end
        end
    end

    // Decoded per channel so an out-of-range addr_q can never index past the vectors.
    always_comb begin
        write_en  = '0;
        fifo_full = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (addr_vld && (addr_q == ADDR_W'(i))) begin
                write_en[i] = write_en_reg;
                fifo_full   = full[i];
            end
        end
    end

    assign valid_out = ~empty;

    // A read always beats a timeout on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
            soft_reset <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (!valid_out[i] || read_en[i]) begin
                    cnt_q[i]      <= '0;
                    soft_reset[i] <= 1'b0;
                end else if (cnt_q[i] == CNT_W'(TIMEOUT - 1)) begin
                    cnt_q[i]      <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    cnt_q[i]      <= cnt_q[i] + 1'b1;
                    soft_reset[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_sync_n.sv
// Bench for router_sync_n (NCH=3, TIMEOUT=30): vector table for steering/address handling,
// hand sequences for timeout, read rescue, simultaneous pulses and mid-count reset.
module tb_router_sync_n;

    localparam int unsigned NCH = 3;

    logic           clk;
    logic           resetn;
    logic           detect_add;
    logic [1:0]     data_in;
    logic           write_en_reg;
    logic [NCH-1:0] read_en;
    logic [NCH-1:0] full;
    logic [NCH-1:0] empty;
    logic [NCH-1:0] valid_out;
    logic [NCH-1:0] soft_reset;
    logic           fifo_full;
    logic [NCH-1:0] write_en;
    logic           addr_err;

    router_sync_n #(
        .NCH    (3),
        .ADDR_W (2),
        .TIMEOUT(30),
        .CNT_W  (5)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .detect_add  (detect_add),
        .data_in     (data_in),
        .write_en_reg(write_en_reg),
        .read_en     (read_en),
        .full        (full),
        .empty       (empty),
        .valid_out   (valid_out),
        .soft_reset  (soft_reset),
        .fifo_full   (fifo_full),
        .write_en    (write_en),
        .addr_err    (addr_err)
    );

    typedef struct {
        logic       rst;
        logic       da;
        logic [1:0] din;
        logic       wer;
        logic [2:0] rd;
        logic [2:0] fl;
        logic [2:0] em;
        logic [2:0] we;
        logic       ff;
        logic [2:0] vo;
        logic [2:0] sr;
        logic       ae;
    } vec_t;

    vec_t    tbl[$];
    vec_t    sb[$];
    string   tag_q[$];
    int      n_vec = 0;
    int      n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic da, logic [1:0] din, logic wer, logic [2:0] fl,
                                logic [2:0] em, logic [2:0] we, logic ff, logic ae);
        vec_t v;
        v.rst = rst; v.da = da; v.din = din; v.wer = wer; v.rd = 3'b000;
        v.fl = fl; v.em = em; v.we = we; v.ff = ff; v.vo = ~em; v.sr = 3'b000; v.ae = ae;
        return v;
    endfunction

    task automatic chk(string tag, string fld, logic [2:0] got, logic [2:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %b want %b", tag, fld, got, exp);
        end
    endtask

    // Drive one cycle just after the rising edge, sample mid-cycle on the falling edge.
    task automatic apply(vec_t v, string tag);
        vec_t e;
        string t;
        @(posedge clk);
        #1;
        resetn       = v.rst;
        detect_add   = v.da;
        data_in      = v.din;
        write_en_reg = v.wer;
        read_en      = v.rd;
        full         = v.fl;
        empty        = v.em;
        sb.push_back(v);
        tag_q.push_back(tag);
        @(negedge clk);
        e = sb.pop_front();
        t = tag_q.pop_front();
        chk(t, "write_en", write_en, e.we);
        chk(t, "fifo_full", {2'b00, fifo_full}, {2'b00, e.ff});
        chk(t, "valid_out", valid_out, e.vo);
        chk(t, "soft_reset", soft_reset, e.sr);
        chk(t, "addr_err", {2'b00, addr_err}, {2'b00, e.ae});
    endtask

    task automatic cyc(logic rst, logic [2:0] em, logic [2:0] rd, logic [2:0] sr, string tag);
        vec_t v;
        v = mk(rst, 1'b0, 2'd0, 1'b0, 3'b000, em, 3'b000, 1'b0, 1'b0);
        v.rd = rd;
        v.sr = sr;
        apply(v, tag);
    endtask

    initial begin
        resetn = 1'b0; detect_add = 1'b0; data_in = '0; write_en_reg = 1'b0;
        read_en = '0; full = '0; empty = '1;

        //            rst da  din  wer full    empty   we      ff  ae
        tbl.push_back(mk(0, 1, 2'd1, 1, 3'b000, 3'b000, 3'b000, 0, 0)); // in reset
        tbl.push_back(mk(0, 1, 2'd1, 1, 3'b000, 3'b000, 3'b000, 0, 0));
        tbl.push_back(mk(1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000, 0, 0));
        tbl.push_back(mk(1, 1, 2'd2, 0, 3'b100, 3'b111, 3'b000, 0, 0)); // header -> 2
        tbl.push_back(mk(1, 0, 2'd0, 1, 3'b100, 3'b111, 3'b100, 1, 0));
        tbl.push_back(mk(1, 0, 2'd0, 1, 3'b011, 3'b111, 3'b100, 0, 0));
        tbl.push_back(mk(1, 0, 2'd0, 0, 3'b100, 3'b111, 3'b000, 1, 0));
        tbl.push_back(mk(1, 1, 2'd0, 1, 3'b001, 3'b111, 3'b100, 0, 0)); // old addr this cycle
        tbl.push_back(mk(1, 0, 2'd0, 1, 3'b001, 3'b111, 3'b001, 1, 0));
        tbl.push_back(mk(1, 1, 2'd3, 1, 3'b001, 3'b111, 3'b001, 1, 0)); // bad address
        tbl.push_back(mk(1, 0, 2'd0, 1, 3'b111, 3'b111, 3'b000, 0, 1));
        tbl.push_back(mk(1, 0, 2'd0, 1, 3'b111, 3'b111, 3'b000, 0, 0));
        tbl.push_back(mk(1, 1, 2'd1, 1, 3'b010, 3'b111, 3'b000, 0, 0));
        tbl.push_back(mk(1, 0, 2'd0, 1, 3'b010, 3'b111, 3'b010, 1, 0));
        tbl.push_back(mk(1, 0, 2'd0, 0, 3'b000, 3'b010, 3'b000, 0, 0));
        tbl.push_back(mk(1, 0, 2'd0, 0, 3'b000, 3'b111, 3'b000, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("vec%0d", i));
        end

        // Timeout: channel 0 valid and unread; pulses after edges 30 and 60 only.
        for (int j = 0; j < 65; j++) begin
            cyc(1'b1, 3'b110, 3'b000, (j > 0 && j % 30 == 0) ? 3'b001 : 3'b000, "timeout");
        end
        cyc(1'b1, 3'b111, 3'b000, 3'b000, "timeout_end");

        // Read on edge 30 rescues the channel; next pulse 30 edges later.
        for (int j = 0; j < 71; j++) begin
            cyc(1'b1, 3'b110, (j == 29) ? 3'b001 : 3'b000, (j == 60) ? 3'b001 : 3'b000,
                "rescue");
        end
        cyc(1'b1, 3'b111, 3'b000, 3'b000, "rescue_end");

        // Channels 1 and 2 valid from the same edge pulse together.
        for (int j = 0; j < 32; j++) begin
            cyc(1'b1, 3'b001, 3'b000, (j == 30) ? 3'b110 : 3'b000, "simul");
        end
        cyc(1'b1, 3'b111, 3'b000, 3'b000, "simul_end");

        // Reset at count 20 restarts the window from release.
        for (int j = 0; j < 20; j++) begin
            cyc(1'b1, 3'b110, 3'b000, 3'b000, "precount");
        end
        cyc(1'b0, 3'b110, 3'b000, 3'b000, "midreset");
        cyc(1'b0, 3'b110, 3'b000, 3'b000, "midreset");
        for (int k = 0; k < 33; k++) begin
            cyc(1'b1, 3'b110, 3'b000, (k == 30) ? 3'b001 : 3'b000, "postreset");
        end
        cyc(1'b1, 3'b111, 3'b000, 3'b000, "final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
